// File: rtl/imm_extend_pipe_if.sv
// rtl/imm_extend_pipe_if.sv - handshake and result bundle for the immediate generator
interface imm_extend_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_BIT    = 3,
    parameter int TAG_WIDTH  = 32
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic [IMM_BIT-1:0]    ImmSrc;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_imm;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  out_err;
    logic [7:0]            err_cnt;

    modport master (
        output flush, in_valid, instr, ImmSrc, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err, err_cnt
    );

    modport slave (
        input  flush, in_valid, instr, ImmSrc, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err, err_cnt
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate generator with a 2-entry output buffer
module imm_extend_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_BIT    = 3,
    parameter int TAG_WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    imm_extend_pipe_if.slave bus
);
    localparam logic [IMM_BIT-1:0] FMT_I     = IMM_BIT'(0);
    localparam logic [IMM_BIT-1:0] FMT_U     = IMM_BIT'(1);
    localparam logic [IMM_BIT-1:0] FMT_S     = IMM_BIT'(2);
    localparam logic [IMM_BIT-1:0] FMT_B     = IMM_BIT'(3);
    localparam logic [IMM_BIT-1:0] FMT_J     = IMM_BIT'(4);
    localparam logic [IMM_BIT-1:0] FMT_SHAMT = IMM_BIT'(5);
    localparam logic [IMM_BIT-1:0] FMT_CSRI  = IMM_BIT'(6);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  err;
    } entry_t;

    entry_t                head_q, head_d;
    entry_t                tail_q, tail_d;
    entry_t                new_entry;
    logic [1:0]            count_q, count_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [DATA_WIDTH-1:0] imm_calc;
    logic                  fmt_err;
    logic                  in_ready;
    logic                  accept;
    logic                  pop;
    logic                  unused_opcode;

    // Opcode bits never feed an immediate.
    assign unused_opcode = ^bus.instr[6:0];

    always_comb begin
        imm_calc = DATA_WIDTH'($signed(bus.instr[31:20]));
        fmt_err  = 1'b0;
        case (bus.ImmSrc)
            FMT_I:     imm_calc = DATA_WIDTH'($signed(bus.instr[31:20]));
            FMT_U:     imm_calc = DATA_WIDTH'($signed({bus.instr[31:12], 12'b0}));
            FMT_S:     imm_calc = DATA_WIDTH'($signed({bus.instr[31:25], bus.instr[11:7]}));
            FMT_B:     imm_calc = DATA_WIDTH'($signed({bus.instr[31], bus.instr[7],
                                                       bus.instr[30:25], bus.instr[11:8], 1'b0}));
            FMT_J:     imm_calc = DATA_WIDTH'($signed({bus.instr[31], bus.instr[19:12],
                                                       bus.instr[20], bus.instr[30:21], 1'b0}));
            FMT_SHAMT: imm_calc = (DATA_WIDTH == 64) ? DATA_WIDTH'(bus.instr[25:20])
                                                     : DATA_WIDTH'(bus.instr[24:20]);
            FMT_CSRI:  imm_calc = DATA_WIDTH'(bus.instr[19:15]);
            // Reserved encodings keep the I-type value but are tagged as errors.
            default:   fmt_err  = 1'b1;
        endcase
    end

    assign new_entry = '{imm: imm_calc, tag: bus.in_tag, err: fmt_err};

    // Ready looks only at occupancy so it never combinationally depends on out_ready.
    assign in_ready = (count_q != 2'd2);
    assign accept   = bus.in_valid && in_ready && !bus.flush;
    assign pop      = (count_q != 2'd0) && bus.out_ready;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (bus.flush) begin
            count_d = 2'd0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (accept) begin
                        head_d  = new_entry;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && pop) begin
                        head_d = new_entry;
                    end else if (accept) begin
                        tail_d  = new_entry;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = 2'd1;
                    end
                end
            endcase
        end
        if (accept && fmt_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= 2'd0;
            err_cnt_q <= 8'd0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Head register is left untouched when the buffer drains, so outputs keep their last value.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_imm   = head_q.imm;
    assign bus.out_tag   = head_q.tag;
    assign bus.out_err   = head_q.err;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - self-checking bench for imm_extend_pipe at 32 and 64 bit widths
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imm_extend_pipe_if #(.DATA_WIDTH(32), .IMM_BIT(3), .TAG_WIDTH(32)) b32 ();
    imm_extend_pipe_if #(.DATA_WIDTH(64), .IMM_BIT(3), .TAG_WIDTH(32)) b64 ();

    imm_extend_pipe #(.DATA_WIDTH(32), .IMM_BIT(3), .TAG_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    imm_extend_pipe #(.DATA_WIDTH(64), .IMM_BIT(3), .TAG_WIDTH(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [31:0] tag;
        logic        err;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        exp_err;
    } vec_t;

    ent_t        q[$];
    ent_t        last;
    int          model_err;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] popped_tags[$];
    vec_t        tv[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference immediate built from field weights rather than bit concatenation.
    function automatic longint ref_imm(input logic [31:0] ins, input logic [2:0] src, input bit w64);
        longint s;
        longint sgn;
        sgn = ins[31] ? 64'sd1 : 64'sd0;
        case (src)
            3'd1: s = -sgn * (longint'(1) <<< 31) + longint'(ins[30:12]) * 4096;
            3'd2: s = -sgn * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
            3'd3: s = -sgn * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            3'd4: s = -sgn * (longint'(1) <<< 20) + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            3'd5: s = w64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd6: s = longint'(ins[19:15]);
            default: s = -sgn * 2048 + longint'(ins[30:20]);
        endcase
        return s;
    endfunction

    task automatic reset_model();
        q.delete();
        model_err = 0;
        last = '{imm32: '0, imm64: '0, tag: '0, err: 1'b0};
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [31:0] tag, input logic ordy, input logic fl);
        b32.in_valid = v;  b32.instr = ins;  b32.ImmSrc = src;  b32.in_tag = tag;
        b32.out_ready = ordy;  b32.flush = fl;
        b64.in_valid = v;  b64.instr = ins;  b64.ImmSrc = src;  b64.in_tag = tag;
        b64.out_ready = ordy;  b64.flush = fl;
    endtask

    task automatic check_all();
        ent_t e;
        e = (q.size() != 0) ? q[0] : last;
        check("out_valid32", b32.out_valid, q.size() != 0);
        check("out_valid64", b64.out_valid, q.size() != 0);
        check("in_ready32", b32.in_ready, q.size() != 2);
        check("in_ready64", b64.in_ready, q.size() != 2);
        check("err_cnt32", b32.err_cnt, model_err);
        check("err_cnt64", b64.err_cnt, model_err);
        check("out_imm32", b32.out_imm, e.imm32);
        check("out_imm64", b64.out_imm, e.imm64);
        check("out_tag32", b32.out_tag, e.tag);
        check("out_tag64", b64.out_tag, e.tag);
        check("out_err32", b32.out_err, e.err);
        check("out_err64", b64.out_err, e.err);
    endtask

    // One clock: drive at negedge, update the model at posedge, check at the next negedge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] src,
                         input logic [31:0] tag, input logic ordy, input logic fl);
        bit     acc;
        bit     pop;
        ent_t   e;
        longint s;
        drive(v, ins, src, tag, ordy, fl);
        #1;
        acc = v && !fl && (q.size() != 2);
        pop = (q.size() != 0) && ordy;
        if (b32.out_valid && ordy) popped_tags.push_back(b32.out_tag);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (fl) q.delete();
        if (acc) begin
            s = ref_imm(ins, src, 1'b0);
            e.imm32 = s[31:0];
            s = ref_imm(ins, src, 1'b1);
            e.imm64 = s;
            e.tag = tag;
            e.err = (src == 3'd7);
            q.push_back(e);
            if (src == 3'd7 && model_err < 255) model_err++;
        end
        if (q.size() != 0) last = q[0];
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        tv[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        tv[1] = '{32'h123452B7, 3'd1, 32'h12345000, 64'h0000000012345000, 1'b0};
        tv[2] = '{32'h800002B7, 3'd1, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        tv[3] = '{32'hFE000FA3, 3'd2, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        tv[4] = '{32'hFE000EE3, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tv[5] = '{32'h0080006F, 3'd4, 32'h00000008, 64'h0000000000000008, 1'b0};
        tv[6] = '{32'h41F05093, 3'd5, 32'h0000001F, 64'h000000000000001F, 1'b0};
        tv[7] = '{32'h02000013, 3'd5, 32'h00000000, 64'h0000000000000020, 1'b0};
        tv[8] = '{32'h000FD073, 3'd6, 32'h0000001F, 64'h000000000000001F, 1'b0};
        tv[9] = '{32'hFFF00093, 3'd7, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0);
        reset_model();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all();

        // Back-to-back table vectors: each result is the head one cycle after its accept.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, tv[i].instr, tv[i].src, 32'(i + 100), 1'b1, 1'b0);
            check("tbl_valid", b32.out_valid, 1'b1);
            check("tbl_imm32", b32.out_imm, tv[i].exp32);
            check("tbl_imm64", b64.out_imm, tv[i].exp64);
            check("tbl_err", b32.out_err, tv[i].exp_err);
            check("tbl_tag", b32.out_tag, 32'(i + 100));
        end
        idle(2);

        // Backpressure: third offer is held until space frees up.
        popped_tags.delete();
        cycle(1'b1, 32'h00100093, 3'd0, 32'd1, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 3'd0, 32'd2, 1'b0, 1'b0);
        check("bp_full_ready", b32.in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h00300093, 3'd0, 32'd3, 1'b0, 1'b0);
            check("bp_stall_tag", b32.out_tag, 32'd1);
            check("bp_stall_imm", b32.out_imm, 32'd1);
            check("bp_stall_ready", b32.in_ready, 1'b0);
        end
        cycle(1'b1, 32'h00300093, 3'd0, 32'd3, 1'b1, 1'b0);
        cycle(1'b1, 32'h00300093, 3'd0, 32'd3, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 3'd0, 32'd0, 1'b1, 1'b0);
        check("bp_pop_count", popped_tags.size(), 3);
        for (int k = 0; k < 3 && k < popped_tags.size(); k++) check("bp_pop_order", popped_tags[k], 32'(k + 1));
        idle(1);

        // Flush at full occupancy with a reserved-format offer in the same cycle.
        cycle(1'b1, 32'h00A00093, 3'd0, 32'd10, 1'b0, 1'b0);
        cycle(1'b1, 32'h00B00093, 3'd0, 32'd11, 1'b0, 1'b0);
        begin
            int saved_err;
            saved_err = model_err;
            cycle(1'b1, 32'h00C00093, 3'd7, 32'd12, 1'b0, 1'b1);
            check("flush_valid", b32.out_valid, 1'b0);
            check("flush_ready", b32.in_ready, 1'b1);
            check("flush_errcnt", b32.err_cnt, 8'(saved_err));
        end
        idle(2);
        check("flush_no_ghost", b32.out_valid, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 500; k++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        idle(3);

        // Reserved-format stream saturates the error counter.
        for (int k = 0; k < 300; k++) begin
            cycle(1'b1, $urandom, 3'd7, 32'(k), 1'b1, 1'b0);
            check("rsv_err", b32.out_err, 1'b1);
        end
        check("rsv_sat32", b32.err_cnt, 8'd255);
        check("rsv_sat64", b64.err_cnt, 8'd255);

        // Asynchronous reset mid-stream, sampled before any clock edge.
        drive(1'b1, 32'hFFF00093, 3'd7, 32'd999, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_errcnt", b32.err_cnt, 8'd0);
        check("arst_valid", b32.out_valid, 1'b0);
        check("arst_imm", b32.out_imm, 32'd0);
        check("arst_errcnt64", b64.err_cnt, 8'd0);
        check("arst_valid64", b64.out_valid, 1'b0);
        reset_model();
        @(negedge clk);
        @(negedge clk);
        check("arst_hold_valid", b32.out_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        check_all();
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
